// File: rtl/fifo_video_reader.sv
// -----------------------------------------------------------------------------
// fifo_video_reader
//
// Read-side consumer of the prefetch sync FIFO. It generates raster timing
// (hs/vs/de) and pops one pixel from the FIFO for every active-video cycle.
// When the FIFO is empty during active video, the timing keeps running.
// A fill pixel is driven instead, and the event is recorded in a sticky flag
// and in a saturating counter.
//
// Ports
//   rd_clk        in   1       clock
//   rd_rst        in   1       asynchronous, active-high reset
//   enable        in   1       start/continue streaming, acted on at frame boundaries
//   uf_clr        in   1       synchronous clear of uf_sticky / uf_count
//   fifo_rd_data  in   DATA_W  FIFO head word (valid when fifo_rd_vld=1)
//   fifo_rd_vld   in   1       FIFO holds a word
//   fifo_rd_en    out  1       pop request (combinational, = internal de)
//   vid_data      out  DATA_W  output pixel
//   vid_de        out  1       active-video qualifier
//   vid_hs        out  1       horizontal sync (active level HS_POL)
//   vid_vs        out  1       vertical sync (active level VS_POL)
//   frame_done    out  1       pulse aligned with the outputs of the last frame cycle
//   uf_sticky     out  1       set on any underflow
//   uf_count      out  16      saturating underflow counter
// -----------------------------------------------------------------------------
module fifo_video_reader #(
  parameter int unsigned      DATA_W   = 24,
  parameter int unsigned      H_ACTIVE = 1280,
  parameter int unsigned      H_FP     = 110,
  parameter int unsigned      H_SYNC   = 40,
  parameter int unsigned      H_BP     = 220,
  parameter int unsigned      V_ACTIVE = 720,
  parameter int unsigned      V_FP     = 5,
  parameter int unsigned      V_SYNC   = 5,
  parameter int unsigned      V_BP     = 20,
  parameter bit               HS_POL   = 1'b1,
  parameter bit               VS_POL   = 1'b1,
  parameter logic [DATA_W-1:0] UF_PIXEL = '0
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  input  logic              uf_clr,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_de,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic              frame_done,
  output logic              uf_sticky,
  output logic [15:0]       uf_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;

  logic run_p0, h_end_p0, v_end_p0;
  logic de_p0, hs_p0, vs_p0, fd_p0, uf_p0;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // ---- stage p0: state machine and raster counters ----
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= S_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign run_p0   = (state == S_RUN);
  assign h_end_p0 = (h_cnt == H_LAST);
  assign v_end_p0 = (v_cnt == V_LAST);

  // Counters are parked at 0 outside RUN so the first RUN cycle is (0,0).
  // enable is only acted upon at the frame end while running, so dropping it
  // mid-frame never truncates the raster.
  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)         state_nxt = S_IDLE;
        else if (fifo_rd_vld) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (h_end_p0) begin
          if (v_end_p0) begin
            if (!enable) state_nxt = S_IDLE;
          end else begin
            v_nxt = v_cnt + VW'(1);
          end
        end else begin
          h_nxt = h_cnt + HW'(1);
          v_nxt = v_cnt;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign de_p0 = run_p0 && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_p0 = run_p0 && (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_p0 = run_p0 && (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign fd_p0 = run_p0 && h_end_p0 && v_end_p0;
  // An empty FIFO in active video does not stall timing; the pop is simply
  // suppressed by the FIFO because rd_vld is low.
  assign uf_p0 = de_p0 && !fifo_rd_vld;

  assign fifo_rd_en = de_p0;

  // ---- stage p1: registered video outputs and underflow bookkeeping ----
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      vid_data   <= '0;
      vid_de     <= 1'b0;
      vid_hs     <= ~HS_POL;
      vid_vs     <= ~VS_POL;
      frame_done <= 1'b0;
      uf_sticky  <= 1'b0;
      uf_count   <= 16'd0;
    end else begin
      vid_de     <= de_p0;
      vid_hs     <= hs_p0 ? HS_POL : ~HS_POL;
      vid_vs     <= vs_p0 ? VS_POL : ~VS_POL;
      frame_done <= fd_p0;
      if (de_p0) begin
        vid_data <= fifo_rd_vld ? fifo_rd_data : UF_PIXEL;
      end
      // A clear request beats an underflow in the same cycle.
      if (uf_clr) begin
        uf_sticky <= 1'b0;
        uf_count  <= 16'd0;
      end else if (uf_p0) begin
        uf_sticky <= 1'b1;
        uf_count  <= sat_inc(uf_count);
      end
    end
  end

endmodule
